// File: rtl/pwm_edge_scheduler.sv
// rtl/pwm_edge_scheduler.sv - per-channel PWM rise/fall edge scheduler with atomic commit
module pwm_edge_scheduler #(
  parameter int WIDTH     = 13,
  parameter int TRANS_NUM = 249
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic [WIDTH*TRANS_NUM-1:0] CYCLE,
  input  logic [WIDTH*TRANS_NUM-1:0] DUTY,
  input  logic [WIDTH*TRANS_NUM-1:0] PHASE,
  output logic [WIDTH*TRANS_NUM-1:0] RISE,
  output logic [WIDTH*TRANS_NUM-1:0] FALL,
  output logic                       BUSY,
  output logic                       DONE
);

  // Intermediates carry two guard bits so 2T - P - D/2 and T - P + D/2 never wrap.
  localparam int EW = WIDTH + 2;
  // The index counter also times DRAIN, so it needs at least two bits.
  localparam int IW = ($clog2(TRANS_NUM) < 2) ? 2 : $clog2(TRANS_NUM);
  localparam logic [IW-1:0] LAST_IDX   = IW'(TRANS_NUM - 1);
  // DRAIN spans the two pipeline stages plus the shadow write of the last channel.
  localparam logic [IW-1:0] DRAIN_LAST = IW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CALC,
    S_DRAIN,
    S_COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0] idx;
  logic          capture_en;
  logic          issue_en;
  logic          commit_en;

  logic [WIDTH-1:0] cyc_q   [TRANS_NUM];
  logic [WIDTH-1:0] duty_q  [TRANS_NUM];
  logic [WIDTH-1:0] phase_q [TRANS_NUM];

  logic             v1;
  logic [IW-1:0]    ch1;
  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] p1;

  logic             v2;
  logic [IW-1:0]    ch2;
  logic [WIDTH-1:0] t2;
  logic             bad2;
  logic [EW-1:0]    rise2;
  logic [EW-1:0]    fall2;

  logic [EW-1:0]    rise_red;
  logic [EW-1:0]    fall_red;
  logic [WIDTH-1:0] rise_mod;
  logic [WIDTH-1:0] fall_mod;

  logic [WIDTH-1:0] rise_sh [TRANS_NUM];
  logic [WIDTH-1:0] fall_sh [TRANS_NUM];

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; START outside IDLE/COMMIT is dropped, never queued
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (START) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_CALC;
      S_CALC:    if (idx == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:   if (idx == DRAIN_LAST) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = START ? S_CAPTURE : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and datapath enables
  always_comb begin
    capture_en = (state == S_CAPTURE);
    issue_en   = (state == S_CALC);
    commit_en  = (state == S_DRAIN) && (idx == DRAIN_LAST);
    BUSY       = (state == S_CAPTURE) || (state == S_CALC) || (state == S_DRAIN);
    DONE       = (state == S_COMMIT);
  end

  // Channel index in CALC, cycle count in DRAIN; restarts on every state change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                  idx <= '0;
    else if (state_nxt != state)                 idx <= '0;
    else if (state == S_CALC || state == S_DRAIN) idx <= idx + 1'b1;
  end

  // Snapshot of all channel inputs; the pass works only from this copy
  always_ff @(posedge CLK) begin
    if (capture_en) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        cyc_q[i]   <= CYCLE[i*WIDTH +: WIDTH];
        duty_q[i]  <= DUTY[i*WIDTH +: WIDTH];
        phase_q[i] <= PHASE[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 1: duty saturation and single phase wrap for the issued channel
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1  <= 1'b0;
      ch1 <= '0;
      t1  <= '0;
      d1  <= '0;
      p1  <= '0;
    end else begin
      v1 <= issue_en;
      if (issue_en) begin
        ch1 <= idx;
        t1  <= cyc_q[idx];
        d1  <= (duty_q[idx] > cyc_q[idx]) ? cyc_q[idx] : duty_q[idx];
        p1  <= (phase_q[idx] >= cyc_q[idx]) ? (phase_q[idx] - cyc_q[idx]) : phase_q[idx];
      end
    end
  end

  // Stage 2: unreduced edge sums; D/2 rounds down for rise and up for fall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v2    <= 1'b0;
      ch2   <= '0;
      t2    <= '0;
      bad2  <= 1'b0;
      rise2 <= '0;
      fall2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        ch2   <= ch1;
        t2    <= t1;
        bad2  <= (t1 < WIDTH'(2));
        rise2 <= (EW'(t1) << 1) - EW'(p1) - EW'(d1 >> 1);
        fall2 <= EW'(t1) - EW'(p1) + EW'(d1 >> 1) + EW'(d1[0]);
      end
    end
  end

  // Modulo T by two conditional subtractions; out-of-range T or an unreduced
  // result (only reachable with P >= 2T) yields zero
  always_comb begin
    rise_red = rise2;
    fall_red = fall2;
    if (rise_red >= EW'(t2)) rise_red = rise_red - EW'(t2);
    if (rise_red >= EW'(t2)) rise_red = rise_red - EW'(t2);
    if (fall_red >= EW'(t2)) fall_red = fall_red - EW'(t2);
    if (fall_red >= EW'(t2)) fall_red = fall_red - EW'(t2);
    rise_mod = (bad2 || (|rise_red[EW-1:WIDTH])) ? '0 : rise_red[WIDTH-1:0];
    fall_mod = (bad2 || (|fall_red[EW-1:WIDTH])) ? '0 : fall_red[WIDTH-1:0];
  end

  // Shadow edge registers, written one channel per cycle as results retire
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        rise_sh[i] <= '0;
        fall_sh[i] <= '0;
      end
    end else if (v2) begin
      rise_sh[ch2] <= rise_mod;
      fall_sh[ch2] <= fall_mod;
    end
  end

  // Committed outputs, updated all at once on the edge entering COMMIT
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RISE <= '0;
      FALL <= '0;
    end else if (commit_en) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        RISE[i*WIDTH +: WIDTH] <= rise_sh[i];
        FALL[i*WIDTH +: WIDTH] <= fall_sh[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_edge_scheduler.sv
// tb/tb_pwm_edge_scheduler.sv - self-checking bench for pwm_edge_scheduler
module tb_pwm_edge_scheduler;

  localparam int W      = 13;
  localparam int N      = 249;
  localparam int LAT    = N + 4;
  localparam int PERIOD = LAT + 1;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           START;
  logic [W*N-1:0] CYCLE;
  logic [W*N-1:0] DUTY;
  logic [W*N-1:0] PHASE;
  logic [W*N-1:0] RISE;
  logic [W*N-1:0] FALL;
  logic           BUSY;
  logic           DONE;

  pwm_edge_scheduler #(.WIDTH(W), .TRANS_NUM(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .CYCLE(CYCLE), .DUTY(DUTY), .PHASE(PHASE),
    .RISE(RISE), .FALL(FALL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int t;
    int d;
    int p;
    int er;
    int ef;
  } vec_t;

  vec_t tbl[8];
  int   t_a[N];
  int   d_a[N];
  int   p_a[N];
  int   er[N];
  int   ef[N];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_rise(input int t, input int d, input int p);
    if (t < 2) return 0;
    if (d > t) d = t;
    if (p >= t) p = p - t;
    return (2 * t - p - d / 2) % t;
  endfunction

  function automatic int ref_fall(input int t, input int d, input int p);
    if (t < 2) return 0;
    if (d > t) d = t;
    if (p >= t) p = p - t;
    return (t - p + (d + 1) / 2) % t;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      CYCLE[i*W +: W] = W'(t_a[i]);
      DUTY[i*W +: W]  = W'(d_a[i]);
      PHASE[i*W +: W] = W'(p_a[i]);
    end
  endtask

  task automatic predict();
    for (int i = 0; i < N; i++) begin
      er[i] = ref_rise(t_a[i], d_a[i], p_a[i]);
      ef[i] = ref_fall(t_a[i], d_a[i], p_a[i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s rise[%0d]", tag, i), int'(RISE[i*W +: W]), er[i]);
      check($sformatf("%s fall[%0d]", tag, i), int'(FALL[i*W +: W]), ef[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Edges are numbered from k0+1; returns the edge number at which DONE appears (-1 if never)
  task automatic wait_done(input int k0, input int limit, output int lat,
                           output int busy_err, output int stab_err);
    logic [W*N-1:0] r0;
    logic [W*N-1:0] f0;
    r0 = RISE;
    f0 = FALL;
    lat = -1;
    busy_err = 0;
    stab_err = 0;
    for (int k = k0 + 1; k <= k0 + limit && lat < 0; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) lat = k;
      else begin
        if (BUSY !== 1'b1) busy_err++;
        if (RISE !== r0 || FALL !== f0) stab_err++;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int be;
    int se;
    int dones;
    int done_k;

    tbl[0] = '{ch: 0,   t: 4096, d: 4096, p: 2048, er: 0,    ef: 0};
    tbl[1] = '{ch: 1,   t: 4096, d: 1000, p: 2048, er: 1548, ef: 2548};
    tbl[2] = '{ch: 5,   t: 2000, d: 1,    p: 0,    er: 0,    ef: 1};
    tbl[3] = '{ch: 7,   t: 2000, d: 0,    p: 0,    er: 0,    ef: 0};
    tbl[4] = '{ch: 10,  t: 0,    d: 50,   p: 7,    er: 0,    ef: 0};
    tbl[5] = '{ch: 11,  t: 1,    d: 1,    p: 0,    er: 0,    ef: 0};
    tbl[6] = '{ch: 12,  t: 100,  d: 150,  p: 10,   er: 40,   ef: 40};
    tbl[7] = '{ch: 248, t: 8191, d: 8191, p: 8190, er: 4097, ef: 4097};

    RST_N = 1'b0;
    START = 1'b0;
    CYCLE = '0;
    DUTY  = '0;
    PHASE = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset rise zero", int'(|RISE), 0);
    check("reset fall zero", int'(|FALL), 0);
    check("reset busy", int'(BUSY), 0);
    check("reset done", int'(DONE), 0);
    RST_N = 1'b1;

    // Directed table pass over a varied background
    for (int i = 0; i < N; i++) begin
      t_a[i] = 3000;
      d_a[i] = 500 + i;
      p_a[i] = (i * 11) % 3000;
    end
    t_a[13] = 100; d_a[13] = 20; p_a[13] = 130;
    foreach (tbl[j]) begin
      t_a[tbl[j].ch] = tbl[j].t;
      d_a[tbl[j].ch] = tbl[j].d;
      p_a[tbl[j].ch] = tbl[j].p;
    end
    drive_inputs();
    predict();
    pulse_start();
    wait_done(0, LAT + 20, lat, be, se);
    check("table latency", lat, LAT);
    check("table busy during pass", be, 0);
    check("table outputs stable during pass", se, 0);
    check("busy low at done", int'(BUSY), 0);
    @(posedge CLK);
    #1;
    check("done single cycle", int'(DONE), 0);
    check("idle after commit busy", int'(BUSY), 0);
    foreach (tbl[j]) begin
      check($sformatf("vec%0d rise", j), int'(RISE[tbl[j].ch*W +: W]), tbl[j].er);
      check($sformatf("vec%0d fall", j), int'(FALL[tbl[j].ch*W +: W]), tbl[j].ef);
    end
    check("phase wrap rise", int'(RISE[13*W +: W]), 60);
    check("phase wrap fall", int'(FALL[13*W +: W]), 80);
    check_outputs("table");

    // START pulses while busy (including late in DRAIN) are ignored
    dones = 0;
    done_k = -1;
    for (int k = 0; k <= LAT + 40; k++) begin
      @(negedge CLK);
      START = (k == 0 || k == 50 || k == 120 || k == LAT - 1);
      @(posedge CLK);
      #1;
      if (DONE) begin
        dones++;
        done_k = k;
      end
    end
    START = 1'b0;
    check("busy-pulse done count", dones, 1);
    check("busy-pulse done edge", done_k, LAT);

    // START held high: back-to-back passes
    @(negedge CLK);
    START = 1'b1;
    wait_done(-1, LAT + 20, lat, be, se);
    check("held first latency", lat, LAT);
    for (int g = 0; g < 2; g++) begin
      wait_done(0, PERIOD + 20, lat, be, se);
      check($sformatf("held gap %0d", g), lat, PERIOD);
      check($sformatf("held gap %0d busy", g), be, 0);
      check($sformatf("held gap %0d stable", g), se, 0);
    end
    START = 1'b0;
    check_outputs("held");
    @(posedge CLK);
    #1;
    check("held stop busy", int'(BUSY), 0);
    check("held stop done", int'(DONE), 0);

    // Reset in the middle of CALC (channel index 100)
    for (int k = 0; k <= 101; k++) begin
      @(negedge CLK);
      START = (k == 0);
      @(posedge CLK);
      #1;
    end
    check("pre-reset busy", int'(BUSY), 1);
    RST_N = 1'b0;
    START = 1'b1;
    #1;
    check("midpass reset rise zero", int'(|RISE), 0);
    check("midpass reset fall zero", int'(|FALL), 0);
    check("midpass reset busy", int'(BUSY), 0);
    check("midpass reset done", int'(DONE), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    RST_N = 1'b1;
    dones = 0;
    be = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
      if (BUSY) be++;
    end
    check("no done after reset", dones, 0);
    check("no busy after reset", be, 0);
    check("rise still zero", int'(|RISE), 0);
    pulse_start();
    wait_done(0, LAT + 20, lat, be, se);
    check("post-reset latency", lat, LAT);
    check("post-reset stable", se, 0);
    check_outputs("post-reset");

    // Randomized passes; inputs are scrambled after capture
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < N; i++) begin
        t_a[i] = int'($urandom_range(8000, 2000));
        d_a[i] = int'($urandom_range(t_a[i], 0));
        p_a[i] = int'($urandom_range(t_a[i], 0));
      end
      drive_inputs();
      predict();
      pulse_start();
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
        t_a[i] = int'($urandom_range(8191, 0));
        d_a[i] = int'($urandom_range(8191, 0));
        p_a[i] = int'($urandom_range(8191, 0));
      end
      drive_inputs();
      wait_done(1, LAT + 20, lat, be, se);
      check($sformatf("rand%0d latency", n), lat, LAT);
      check($sformatf("rand%0d busy", n), be, 0);
      check($sformatf("rand%0d stable", n), se, 0);
      check_outputs($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
